// File: rtl/calc_pkg.sv
// Shared constants for the calculator: one-hot operation codes and FSM states.
package calc_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/calc_div.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// The first iteration happens on the start edge so ready rises WIDTH cycles after start.
module calc_div
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready,
   output logic             div0
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_active;
   logic             r_ready;
   logic             r_div0;

   logic [WIDTH-1:0] w_src_rem;
   logic [WIDTH-1:0] w_src_quo;
   logic [WIDTH-1:0] w_src_b;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH:0]   w_diff;

   // One restoring step; on start it operates on the fresh operands instead of the registers.
   always_comb begin
      w_src_rem = start ? '0 : r_rem;
      w_src_quo = start ? a  : r_quo;
      w_src_b   = start ? b  : r_b;
      w_trial   = {w_src_rem, w_src_quo[WIDTH-1]};
      w_diff    = w_trial - {1'b0, w_src_b};
      if (w_diff[WIDTH]) begin
         w_rem_nxt = w_trial[WIDTH-1:0];
         w_quo_nxt = {w_src_quo[WIDTH-2:0], 1'b0};
      end else begin
         w_rem_nxt = w_diff[WIDTH-1:0];
         w_quo_nxt = {w_src_quo[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_ready  <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         if (start) begin
            r_b    <= b;
            r_div0 <= (b == '0);
            if (b != '0) begin
               r_rem    <= w_rem_nxt;
               r_quo    <= w_quo_nxt;
               r_cnt    <= CW'(WIDTH - 1);
               r_active <= 1'b1;
            end else begin
               r_rem    <= '0;
               r_quo    <= '0;
               r_cnt    <= '0;
               r_active <= 1'b0;
            end
         end else if (r_active) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_active <= 1'b0;
               r_ready  <= 1'b1;
            end
         end
      end
   end

   assign quotient  = r_quo;
   assign remainder = r_rem;
   assign ready     = r_ready;
   assign div0      = r_div0;

endmodule

// File: rtl/calc_engine.sv
// Multi-cycle ADD/SUB/MUL/DIV engine: IDLE -> EXEC -> DONE with registered results.
module calc_engine
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          SIGNED_SUB = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_ovf,
   output logic             flag_err
);

   localparam int unsigned PW = 2 * WIDTH;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_flag_ovf;
   logic             r_flag_err;

   logic             w_accept;
   logic             w_capture;
   logic             w_div_start;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;
   logic             w_div_ready;
   logic             w_div0;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [PW-1:0]    w_prod;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_hi;
   logic             w_ovf;
   logic             w_err;

   assign w_div_start = w_accept && (op == OP_DIV);

   calc_div #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (w_div_start),
      .a         (a),
      .b         (b),
      .quotient  (w_quo),
      .remainder (w_rem),
      .ready     (w_div_ready),
      .div0      (w_div0)
   );

   // Next state; EXEC is held only while a real division is still iterating.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!((r_op == OP_DIV) && !w_div0 && !w_div_ready)) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Result selection from the latched operands.
   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, r_b};
      w_diff = r_a - r_b;
      w_prod = PW'(r_a) * PW'(r_b);
      w_res  = '0;
      w_hi   = '0;
      w_ovf  = 1'b0;
      w_err  = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_ovf = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_res = w_diff;
            if (SIGNED_SUB)
               w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            else
               w_ovf = (r_a < r_b);
         end
         OP_MUL: begin
            w_res = w_prod[WIDTH-1:0];
            w_hi  = w_prod[PW-1:WIDTH];
            w_ovf = (w_prod[PW-1:WIDTH] != '0);
         end
         OP_DIV: begin
            if (w_div0) begin
               w_res = '1;
               w_hi  = r_a;
               w_err = 1'b1;
            end else begin
               w_res = w_quo;
               w_hi  = w_rem;
            end
         end
         default: w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flag_ovf  <= 1'b0;
         r_flag_err  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_EXEC);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
         end
         if (w_capture) begin
            r_result    <= w_res;
            r_result_hi <= w_hi;
            r_flag_ovf  <= w_ovf;
            r_flag_err  <= w_err;
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flag_ovf  = r_flag_ovf;
   assign flag_err  = r_flag_err;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: directed vectors at WIDTH=8, randomized model check at WIDTH=16.
module tb_calc_engine;

   logic        clk;
   logic        rst;
   logic        start8, busy8, done8, ovf8, err8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8, res8, hi8;
   logic        start16, busy16, done16, ovf16, err16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, res16, hi16;

   int n_tests = 0;
   int n_fail  = 0;

   calc_engine #(.WIDTH(8), .SIGNED_SUB(1'b0)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
      .flag_ovf(ovf8), .flag_err(err8)
   );

   calc_engine #(.WIDTH(16), .SIGNED_SUB(1'b1)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .result(res16), .result_hi(hi16),
      .flag_ovf(ovf16), .flag_err(err16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [7:0] hi;
      logic       ovf;
      logic       err;
      int         lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one operation and wait for done; returns in the idle cycle after done.
   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [7:0] h,
                       output logic ov, output logic er, output int lat);
      start8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(posedge clk); #1;
      start8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!done8 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = res8; h = hi8; ov = ovf8; er = err8;
      @(posedge clk); #1;
   endtask

   task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic [15:0] h,
                        output logic ov, output logic er, output int lat);
      start16 = 1'b1; op16 = op; a16 = a; b16 = b;
      @(posedge clk); #1;
      start16 = 1'b0; op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 1;
      while (!done16 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r = res16; h = hi16; ov = ovf16; er = err16;
      @(posedge clk); #1;
   endtask

   // Reference behaviour from plain integer arithmetic.
   task automatic model16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [15:0] h,
                          output logic ov, output logic er, output int lat);
      longint ua, ub, sa, sb, t;
      ua = longint'(a); ub = longint'(b);
      r = '0; h = '0; ov = 1'b0; er = 1'b0; lat = 2;
      case (op)
         4'b0001: begin t = ua + ub; r = 16'(t); ov = (t > 65535); end
         4'b0010: begin
            r  = 16'(ua - ub);
            sa = (ua >= 32768) ? ua - 65536 : ua;
            sb = (ub >= 32768) ? ub - 65536 : ub;
            t  = sa - sb;
            ov = (t > 32767) || (t < -32768);
         end
         4'b0100: begin t = ua * ub; r = 16'(t); h = 16'(t / 65536); ov = (t / 65536) != 0; end
         4'b1000: begin
            if (ub == 0) begin r = 16'hFFFF; h = a; er = 1'b1; end
            else begin r = 16'(ua / ub); h = 16'(ua % ub); lat = 17; end
         end
         default: er = 1'b1;
      endcase
   endtask

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic [7:0]  r8, h8;
      logic [15:0] r16, h16, er16, eh16;
      logic        ov, er, eov, eer;
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      logic [3:0]  bad_ops[8];
      int          lat, elat, ndone;

      vecs[0]  = '{4'b0001, 8'd200, 8'd100, 8'd44,  8'd0, 1'b1, 1'b0, 2};
      vecs[1]  = '{4'b0100, 8'd25,  8'd12,  8'd44,  8'd1, 1'b1, 1'b0, 2};
      vecs[2]  = '{4'b0010, 8'd5,   8'd7,   8'd254, 8'd0, 1'b1, 1'b0, 2};
      vecs[3]  = '{4'b1000, 8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 1'b0, 9};
      vecs[4]  = '{4'b1000, 8'd9,   8'd0,   8'd255, 8'd9, 1'b0, 1'b1, 2};
      vecs[5]  = '{4'b0011, 8'd3,   8'd4,   8'd0,   8'd0, 1'b0, 1'b1, 2};
      vecs[6]  = '{4'b0000, 8'd9,   8'd9,   8'd0,   8'd0, 1'b0, 1'b1, 2};
      vecs[7]  = '{4'b0001, 8'd255, 8'd1,   8'd0,   8'd0, 1'b1, 1'b0, 2};
      vecs[8]  = '{4'b0010, 8'd0,   8'd0,   8'd0,   8'd0, 1'b0, 1'b0, 2};
      vecs[9]  = '{4'b0010, 8'd7,   8'd5,   8'd2,   8'd0, 1'b0, 1'b0, 2};
      vecs[10] = '{4'b0100, 8'd15,  8'd17,  8'd255, 8'd0, 1'b0, 1'b0, 2};
      vecs[11] = '{4'b1000, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 1'b0, 9};
      vecs[12] = '{4'b1000, 8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 1'b0, 9};
      bad_ops  = '{4'b0000, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1100, 4'b1110, 4'b1111};

      rst = 1'b1;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", busy8, 0);
      check("rst.done", done8, 0);
      check("rst.result", res8, 0);
      check("rst.result_hi", hi8, 0);
      check("rst.ovf", ovf8, 0);
      check("rst.err", err8, 0);

      // start together with rst must not be accepted
      start8 = 1'b1; op8 = 4'b0001; a8 = 8'd1; b8 = 8'd1;
      @(posedge clk); #1;
      check("rst_start.busy0", busy8, 0);
      rst = 1'b0; start8 = 1'b0;
      @(posedge clk); #1;
      check("rst_start.busy1", busy8, 0);
      check("rst_start.done1", done8, 0);

      // explicit ADD timing: busy at start+1, done at start+2
      start8 = 1'b1; op8 = 4'b0001; a8 = 8'd200; b8 = 8'd100;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("add_t.busy", busy8, 1);
      check("add_t.done_early", done8, 0);
      @(posedge clk); #1;
      check("add_t.done", done8, 1);
      check("add_t.busy_in_done", busy8, 0);
      check("add_t.result", res8, 44);
      @(posedge clk); #1;
      check("add_t.done_pulse", done8, 0);

      for (int i = 0; i < 13; i++) begin
         run8(vecs[i].op, vecs[i].a, vecs[i].b, r8, h8, ov, er, lat);
         check($sformatf("vec%0d.result", i), r8, vecs[i].res);
         check($sformatf("vec%0d.result_hi", i), h8, vecs[i].hi);
         check($sformatf("vec%0d.ovf", i), ov, vecs[i].ovf);
         check($sformatf("vec%0d.err", i), er, vecs[i].err);
         check($sformatf("vec%0d.latency", i), lat, vecs[i].lat);
      end

      // outputs hold across a new start until the next done
      start8 = 1'b1; op8 = 4'b0100; a8 = 8'd25; b8 = 8'd12;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("hold.result", res8, vecs[12].res);
      check("hold.result_hi", hi8, vecs[12].hi);
      lat = 1;
      while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
      check("hold.new_result", res8, 44);
      @(posedge clk); #1;

      // second start during a DIV is ignored; exactly one done
      start8 = 1'b1; op8 = 4'b1000; a8 = 8'd200; b8 = 8'd7;
      @(posedge clk); #1;
      start8 = 1'b0;
      ndone = 0; elat = 0;
      for (int c = 2; c <= 25; c++) begin
         if (c == 4) begin start8 = 1'b1; op8 = 4'b0001; a8 = 8'd1; b8 = 8'd1; end
         if (c == 5) start8 = 1'b0;
         @(posedge clk); #1;
         if (done8) begin ndone++; elat = c; r8 = res8; h8 = hi8; end
      end
      check("busy_start.ndone", ndone, 1);
      check("busy_start.latency", elat, 9);
      check("busy_start.result", r8, 28);
      check("busy_start.result_hi", h8, 4);

      // reset mid-division abandons the operation
      start8 = 1'b1; op8 = 4'b1000; a8 = 8'd200; b8 = 8'd7;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("middiv.busy", busy8, 0);
      check("middiv.done", done8, 0);
      check("middiv.result", res8, 0);
      check("middiv.result_hi", hi8, 0);
      check("middiv.ovf", ovf8, 0);
      check("middiv.err", err8, 0);
      ndone = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done8 || busy8) ndone++;
      end
      check("middiv.no_activity", ndone, 0);
      run8(4'b0001, 8'd3, 8'd4, r8, h8, ov, er, lat);
      check("after_rst.result", r8, 7);
      check("after_rst.latency", lat, 2);
      check("after_rst.ovf", ov, 0);

      // randomized WIDTH=16 against the reference model
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    rop = 4'b0001;
            2, 3:    rop = 4'b0010;
            4, 5:    rop = 4'b0100;
            6, 7, 8: rop = 4'b1000;
            default: rop = bad_ops[$urandom_range(0, 7)];
         endcase
         ra = pick16();
         rb = pick16();
         model16(rop, ra, rb, er16, eh16, eov, eer, elat);
         run16(rop, ra, rb, r16, h16, ov, er, lat);
         n_tests++;
         if (r16 != er16 || h16 != eh16 || ov != eov || er != eer || lat != elat) begin
            n_fail++;
            $display("FAIL rand%0d op=%b a=%0d b=%0d: got res=%0d hi=%0d ovf=%0d err=%0d lat=%0d, expected res=%0d hi=%0d ovf=%0d err=%0d lat=%0d",
                     i, rop, ra, rb, r16, h16, ov, er, lat, er16, eh16, eov, eer, elat);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
